// File: rtl/spi_frame_pkg.sv
// spi_frame_pkg: shared FSM encoding and frame-format constants for spi_frame_master.
//   IDLE/SETUP/SHIFT/HOLD/GAP state encoding, address-byte field layout,
//   and the frame length (address byte + NBIT data bits).
package spi_frame_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
    localparam int ADR_W  = 7;
    localparam int RW_BIT = 7;
    function automatic int frame_len(input int nbit);
        return 8 + nbit;
    endfunction
endpackage

// File: rtl/spi_half_tick.sv
// spi_half_tick: sclk half-period timer; one-cycle tick every CLK_DIV cycles.
//   clk, rst : clock, asynchronous active-high reset
//   load     : restarts the period so the first tick is CLK_DIV cycles later
//   tick     : high in the last cycle of each half-period
module spi_half_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tick
);
    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = cnt_q == '0;

    always_comb begin
        cnt_d = (load || tick) ? CW'(CLK_DIV - 1) : cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/spi_frame_master.sv
// spi_frame_master: serialises {rw, adr, wdata} MSB-first as an SPI frame.
//   clk, rst        : clock, asynchronous active-high reset
//   start/ready     : command handshake, accepted only when ready=1
//   rw, adr, wdata  : command fields (rw=1 write, 0 read)
//   done            : one-cycle pulse at frame end (same cycle cs rises)
//   rdata           : read data captured from miso
//   sclk, mosi, cs  : SPI outputs (sclk idles low, cs active low)
//   miso            : SPI input, asynchronous
// Optional readback: define SPI_FRAME_MASTER_READBACK_EN to synchronise miso
// and capture read data; otherwise rdata is 0 and miso is ignored.
module spi_frame_master
    import spi_frame_pkg::*;
#(
    parameter int NBIT    = 8,
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    input  logic             rw,
    input  logic [ADR_W-1:0] adr,
    input  logic [NBIT-1:0]  wdata,
    output logic             done,
    output logic [NBIT-1:0]  rdata,
    output logic             sclk,
    output logic             mosi,
    output logic             cs,
    input  logic             miso
);
    localparam int FRAME = frame_len(NBIT);
    localparam int BW    = $clog2(FRAME);
    localparam int GW    = $clog2(CS_GAP + 1);

    state_t           state_q, state_d;
    logic [FRAME-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             sclk_q, sclk_d, cs_q, cs_d, mosi_q, mosi_d;
    logic             done_q, done_d, ready_q, ready_d;
    logic             load, tick;

    spi_half_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                shift_d = {rw, adr, wdata};
                mosi_d  = rw;
                cs_d    = 1'b0;
                bit_d   = '0;
                load    = 1'b1;
                state_d = SETUP;
            end
            SETUP: if (tick) begin
                sclk_d  = 1'b1;
                state_d = SHIFT;
            end
            // The low half of the last bit is the HOLD phase, so mosi is
            // left untouched on the final falling edge.
            SHIFT: if (tick) begin
                sclk_d = ~sclk_q;
                if (sclk_q && bit_q == BW'(FRAME - 1)) begin
                    state_d = HOLD;
                end else if (sclk_q) begin
                    shift_d = shift_q << 1;
                    mosi_d  = shift_q[FRAME-2];
                    bit_d   = bit_q + 1'b1;
                end
            end
            HOLD: if (tick) begin
                cs_d    = 1'b1;
                mosi_d  = 1'b0;
                done_d  = 1'b1;
                gap_d   = GW'(CS_GAP - 1);
                state_d = GAP;
            end
            GAP: begin
                gap_d   = (gap_q == '0) ? gap_q : gap_q - 1'b1;
                state_d = (gap_q == '0) ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
        ready_d = state_d == IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign sclk  = sclk_q;
    assign cs    = cs_q;
    assign mosi  = mosi_q;

`ifdef SPI_FRAME_MASTER_READBACK_EN
    logic [1:0]      sync_q;
    logic            rw_q, rw_d;
    logic [NBIT-1:0] cap_q, cap_d, rdata_q, rdata_d;

    // Sample in the last cycle of each sclk high half of the data bits;
    // the 2-cycle synchroniser latency fits well inside CLK_DIV >= 4.
    always_comb begin
        rw_d    = (state_q == IDLE && start) ? rw : rw_q;
        cap_d   = (state_q == SHIFT && sclk_q && tick && !rw_q && bit_q >= BW'(8))
                ? {cap_q[NBIT-2:0], sync_q[1]} : cap_q;
        rdata_d = (state_q == HOLD && tick && !rw_q) ? cap_q : rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            rw_q    <= 1'b0;
            cap_q   <= '0;
            rdata_q <= '0;
        end else begin
            sync_q  <= {sync_q[0], miso};
            rw_q    <= rw_d;
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
`else
    logic unused_miso;
    assign unused_miso = miso;
    assign rdata       = '0;
`endif
endmodule

// File: tb/tb_spi_frame_master.sv
// tb_spi_frame_master: directed bench for spi_frame_master.
//   Instance 0 uses defaults (CLK_DIV=4), instance 1 uses CLK_DIV=6.
//   A negedge monitor measures frame timing relative to the accept cycle.
module tb_spi_frame_master;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rw = 1'b0;
    logic [6:0] adr = '0;
    logic [7:0] wdata = '0;
    logic [1:0] start_w = '0, miso_w, ready_w, done_w, sclk_w, mosi_w, cs_w;
    logic [7:0] rdata_w [2];

    int cyc = 0, checks = 0, errs = 0;
    int acc [2], prev_acc [2], gap_meas [2], done_abs [2];
    int csf [2], csr [2], donet [2], ndone [2], nrise [2], last_rise [2], unstable [2];
    int run [2], hmin [2], hmax [2], lmin [2], lmax [2];
    logic [15:0] bits [2], mpat [2];
    logic [7:0]  rdv [2];
    logic [1:0]  psclk, pcs, pmosi;

`ifdef SPI_FRAME_MASTER_READBACK_EN
    localparam logic [7:0] EXP_RD = 8'h3C;
`else
    localparam logic [7:0] EXP_RD = 8'h00;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_frame_master u0 (
        .clk(clk), .rst(rst), .start(start_w[0]), .ready(ready_w[0]), .rw(rw),
        .adr(adr), .wdata(wdata), .done(done_w[0]), .rdata(rdata_w[0]),
        .sclk(sclk_w[0]), .mosi(mosi_w[0]), .cs(cs_w[0]), .miso(miso_w[0])
    );

    spi_frame_master #(.NBIT(8), .CLK_DIV(6), .CS_GAP(8)) u1 (
        .clk(clk), .rst(rst), .start(start_w[1]), .ready(ready_w[1]), .rw(rw),
        .adr(adr), .wdata(wdata), .done(done_w[1]), .rdata(rdata_w[1]),
        .sclk(sclk_w[1]), .mosi(mosi_w[1]), .cs(cs_w[1]), .miso(miso_w[1])
    );

    initial begin
        miso_w = '0;
        psclk  = '0;
        pcs    = '1;
        pmosi  = '0;
        for (int i = 0; i < 2; i++) begin
            acc[i] = 0; prev_acc[i] = 0; gap_meas[i] = 0; done_abs[i] = 0;
            csf[i] = -1; csr[i] = -1; donet[i] = -1; ndone[i] = 0; nrise[i] = 0;
            last_rise[i] = -1; unstable[i] = 0; run[i] = 0; bits[i] = '0;
            mpat[i] = '0; rdv[i] = '0;
            hmin[i] = 999; hmax[i] = 0; lmin[i] = 999; lmax[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                int rel;
                if (ready_w[i] && start_w[i]) begin
                    prev_acc[i] = acc[i];
                    acc[i]      = cyc;
                    gap_meas[i] = cyc - done_abs[i];
                    nrise[i] = 0; bits[i] = '0; unstable[i] = 0;
                    hmin[i] = 999; hmax[i] = 0; lmin[i] = 999; lmax[i] = 0;
                end
                rel = cyc - acc[i];
                if (sclk_w[i] != psclk[i]) begin
                    if (psclk[i]) begin
                        hmin[i] = (run[i] < hmin[i]) ? run[i] : hmin[i];
                        hmax[i] = (run[i] > hmax[i]) ? run[i] : hmax[i];
                    end else begin
                        if (nrise[i] > 0) begin
                            lmin[i] = (run[i] < lmin[i]) ? run[i] : lmin[i];
                            lmax[i] = (run[i] > lmax[i]) ? run[i] : lmax[i];
                        end
                        miso_w[i]    = (nrise[i] < 16) ? mpat[i][15 - nrise[i]] : 1'b0;
                        bits[i]      = {bits[i][14:0], mosi_w[i]};
                        nrise[i]     = nrise[i] + 1;
                        last_rise[i] = rel;
                    end
                    run[i] = 1;
                end else begin
                    run[i] = run[i] + 1;
                end
                if (sclk_w[i] && psclk[i] && mosi_w[i] != pmosi[i]) unstable[i] = unstable[i] + 1;
                if (!cs_w[i] && pcs[i]) csf[i] = rel;
                if (cs_w[i] && !pcs[i]) csr[i] = rel;
                if (done_w[i]) begin
                    donet[i]    = rel;
                    ndone[i]    = ndone[i] + 1;
                    done_abs[i] = cyc;
                    rdv[i]      = rdata_w[i];
                end
                psclk[i] = sclk_w[i];
                pcs[i]   = cs_w[i];
                pmosi[i] = mosi_w[i];
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int i, input logic r, input logic [6:0] a,
                        input logic [7:0] d, input logic [15:0] mp);
        @(posedge clk);
        #1;
        rw = r; adr = a; wdata = d; mpat[i] = mp; start_w[i] = 1'b1;
        @(posedge clk);
        #1;
        start_w[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget);
        int n0 = ndone[i];
        int k = 0;
        while (ndone[i] == n0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("done_timeout", int'(ndone[i] != n0), 1);
    endtask

    initial begin
        int n0, a0;
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(ready_w[0]), 1);
        chk("rst_cs", int'(cs_w[0]), 1);
        chk("rst_sclk", int'(sclk_w[0]), 0);
        chk("rst_mosi", int'(mosi_w[0]), 0);
        chk("rst_done", int'(done_w[0]), 0);
        chk("rst_rdata", int'(rdata_w[0]), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // write rw=1 adr=0x01 wdata=0xA5
        send(0, 1'b1, 7'h01, 8'hA5, 16'h0000);
        wait_done(0, 400);
        chk("wr_bits", int'(bits[0]), 16'h81A5);
        chk("wr_nrise", nrise[0], 16);
        chk("wr_cs_fall", csf[0], 1);
        chk("wr_last_rise", last_rise[0], 125);
        chk("wr_cs_rise", csr[0], 133);
        chk("wr_done_t", donet[0], 133);
        chk("wr_rdata", int'(rdv[0]), 0);
        chk("wr_hi_len", hmin[0] * 1000 + hmax[0], 4004);
        chk("wr_lo_len", lmin[0] * 1000 + lmax[0], 4004);
        chk("wr_mosi_stable", unstable[0], 0);
        repeat (12) @(posedge clk);

        // read rw=0 adr=0x01 with miso = 0x3C on the data bits
        send(0, 1'b0, 7'h01, 8'h00, 16'h003C);
        wait_done(0, 400);
        chk("rd_bits", int'(bits[0]), 16'h0100);
        chk("rd_done_t", donet[0], 133);
        chk("rd_rdata", int'(rdv[0]), int'(EXP_RD));
        repeat (12) @(posedge clk);

        // start held high: second accept exactly 141 cycles after the first
        n0 = ndone[0];
        @(posedge clk);
        #1 rw = 1'b1; adr = 7'h01; wdata = 8'h3C; start_w[0] = 1'b1;
        wait_done(0, 400);
        a0 = acc[0];
        for (int k = 0; k < 50 && acc[0] == a0; k++) @(posedge clk);
        #1 start_w[0] = 1'b0;
        chk("held_accept_period", acc[0] - prev_acc[0], 141);
        chk("held_cs_gap", gap_meas[0], 8);
        wait_done(0, 400);
        repeat (200) @(posedge clk);
        chk("held_frame_count", ndone[0] - n0, 2);

        // reset at cycle 60 of a frame
        send(0, 1'b1, 7'h01, 8'hFF, 16'h0000);
        for (int k = 0; k < 100 && (cyc - acc[0]) != 60; k++) @(negedge clk);
        n0 = ndone[0];
        rst = 1'b1;
        #1;
        chk("midrst_cs", int'(cs_w[0]), 1);
        chk("midrst_sclk", int'(sclk_w[0]), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (200) @(posedge clk);
        chk("midrst_no_done", ndone[0] - n0, 0);
        send(0, 1'b1, 7'h01, 8'h5A, 16'h0000);
        wait_done(0, 400);
        chk("post_rst_bits", int'(bits[0]), 16'h815A);
        chk("post_rst_done_t", donet[0], 133);
        repeat (12) @(posedge clk);

        // CLK_DIV=6 instance
        send(1, 1'b1, 7'h01, 8'hA5, 16'h0000);
        wait_done(1, 600);
        chk("div6_hi_len", hmin[1] * 1000 + hmax[1], 6006);
        chk("div6_lo_len", lmin[1] * 1000 + lmax[1], 6006);
        chk("div6_done_t", donet[1], 199);
        chk("div6_bits", int'(bits[1]), 16'h81A5);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
